// File: rtl/car_request_conditioner.sv
// Conditions the raw north/east car sensors into held arbiter requests.
// Each direction has a synchronizer, a debounce filter, a request FSM, a wait counter and a starve flag.

module car_request_dir #(
    parameter int DEB_CYCLES   = 4,
    parameter int WAIT_W       = 8,
    parameter int STARVE_LIMIT = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sensor,
    input  logic              grant,
    input  logic              hold,
    output logic              req,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              starve
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_SERVE = 2'd2
    } state_e;

    localparam logic [3:0]        DEB_LAST  = 4'(DEB_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] LIMIT     = WAIT_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

    // The wait count pins at its maximum instead of wrapping back to zero.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        logic [WAIT_W-1:0] r;
        if (v == WAIT_MAX) begin
            r = v;
        end else begin
            r = v + WAIT_ONE;
        end
        return r;
    endfunction

    logic [1:0]        sync_q, sync_d;
    logic              filt_q, filt_d;
    logic [3:0]        stab_q, stab_d;
    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              req_q, req_d;
    logic              starve_q, starve_d;
    logic              synced_s;

    assign synced_s = sync_q[1];

    // Two-stage synchronizer shift for the asynchronous sensor.
    always_comb begin
        sync_d = {sync_q[0], sensor};
    end

    // Debounce: adopt the synchronized level only after DEB_CYCLES consecutive mismatches.
    always_comb begin
        filt_d = filt_q;
        stab_d = stab_q;
        if (synced_s != filt_q) begin
            if (stab_q >= DEB_LAST) begin
                filt_d = synced_s;
                stab_d = 4'd0;
            end else begin
                stab_d = stab_q + 4'd1;
            end
        end else begin
            stab_d = 4'd0;
        end
    end

    // Request FSM next state; a conflicting double grant freezes it for the cycle.
    always_comb begin
        state_d = state_q;
        if (hold) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (filt_q && grant) begin
                        state_d = ST_SERVE;
                    end else if (filt_q) begin
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PEND: begin
                    if (grant) begin
                        state_d = ST_SERVE;
                    end else begin
                        state_d = ST_PEND;
                    end
                end
                ST_SERVE: begin
                    if (grant) begin
                        state_d = ST_SERVE;
                    end else if (filt_q) begin
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Wait counter, request and starve flag; starve compares the next count so it tracks wait_cnt exactly.
    always_comb begin
        wait_d = wait_q;
        if (hold) begin
            wait_d = wait_q;
        end else if (state_q == ST_PEND) begin
            if (state_d != ST_PEND) begin
                wait_d = {WAIT_W{1'b0}};
            end else begin
                wait_d = sat_inc(wait_q);
            end
        end else begin
            wait_d = {WAIT_W{1'b0}};
        end
        req_d    = (state_d == ST_PEND);
        starve_d = (wait_d >= LIMIT);
    end

    // State registers for this direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b00;
            filt_q   <= 1'b0;
            stab_q   <= 4'd0;
            state_q  <= ST_IDLE;
            wait_q   <= {WAIT_W{1'b0}};
            req_q    <= 1'b0;
            starve_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            filt_q   <= filt_d;
            stab_q   <= stab_d;
            state_q  <= state_d;
            wait_q   <= wait_d;
            req_q    <= req_d;
            starve_q <= starve_d;
        end
    end

    assign req      = req_q;
    assign wait_cnt = wait_q;
    assign starve   = starve_q;

endmodule

module car_request_conditioner #(
    parameter int DEB_CYCLES   = 4,
    parameter int WAIT_W       = 8,
    parameter int STARVE_LIMIT = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sn,
    input  logic              se,
    input  logic              gn,
    input  logic              ge,
    output logic              cn,
    output logic              ce,
    output logic [WAIT_W-1:0] wait_n,
    output logic [WAIT_W-1:0] wait_e,
    output logic [1:0]        starve,
    output logic              grant_err
);

    logic [1:0] rst_sync_q;
    logic       rst_int_n;
    logic       both_grant_s;
    logic       grant_err_q, grant_err_d;
    logic       starve_n_s, starve_e_s;

    // Reset asserts asynchronously but is released only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n    = rst_sync_q[1];
    assign both_grant_s = gn & ge;

    // Sticky record of the arbiter ever granting both directions at once.
    always_comb begin
        if (both_grant_s) begin
            grant_err_d = 1'b1;
        end else begin
            grant_err_d = grant_err_q;
        end
    end

    // Grant error flag register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            grant_err_q <= 1'b0;
        end else begin
            grant_err_q <= grant_err_d;
        end
    end

    car_request_dir #(
        .DEB_CYCLES  (DEB_CYCLES),
        .WAIT_W      (WAIT_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_north (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .sensor  (sn),
        .grant   (gn),
        .hold    (both_grant_s),
        .req     (cn),
        .wait_cnt(wait_n),
        .starve  (starve_n_s)
    );

    car_request_dir #(
        .DEB_CYCLES  (DEB_CYCLES),
        .WAIT_W      (WAIT_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_east (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .sensor  (se),
        .grant   (ge),
        .hold    (both_grant_s),
        .req     (ce),
        .wait_cnt(wait_e),
        .starve  (starve_e_s)
    );

    assign starve    = {starve_e_s, starve_n_s};
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_car_request_conditioner.sv
// Scoreboard bench for car_request_conditioner: stimulus queues timed expectations, a monitor checks them.

module tb_car_request_conditioner;

    localparam int SEL_CN = 0, SEL_CE = 1, SEL_WN = 2, SEL_WE = 3, SEL_ST = 4, SEL_GE = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sn = 1'b0, se = 1'b0, gn = 1'b0, ge = 1'b0;
    logic       cn, ce;
    logic [7:0] wait_n, wait_e;
    logic [1:0] starve;
    logic       grant_err;

    typedef struct {
        int    due;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    car_request_conditioner #(
        .DEB_CYCLES  (4),
        .WAIT_W      (8),
        .STARVE_LIMIT(200)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sn       (sn),
        .se       (se),
        .gn       (gn),
        .ge       (ge),
        .cn       (cn),
        .ce       (ce),
        .wait_n   (wait_n),
        .wait_e   (wait_e),
        .starve   (starve),
        .grant_err(grant_err)
    );

    function automatic int observe(input int sel);
        case (sel)
            SEL_CN:  return int'(cn);
            SEL_CE:  return int'(ce);
            SEL_WN:  return int'(wait_n);
            SEL_WE:  return int'(wait_e);
            SEL_ST:  return int'(starve);
            SEL_GE:  return int'(grant_err);
            default: return -1;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_at(input int d, input int sel, input int val, input string name);
        sb.push_back('{cyc + d, sel, val, name});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sn = 1'b0; se = 1'b0; gn = 1'b0; ge = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(4);
    endtask

    // Monitor: compare every expectation that falls due on this cycle.
    always @(negedge clk) begin : monitor
        exp_t keep[$];
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
                check(sb[i].name, observe(sb[i].sel), sb[i].val);
            end else if (sb[i].due < cyc) begin
                check({sb[i].name, "_late"}, -1, sb[i].val);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        do_reset();
        exp_at(1, SEL_CN, 0, "rst_cn");
        exp_at(1, SEL_CE, 0, "rst_ce");
        exp_at(1, SEL_WN, 0, "rst_wait_n");
        exp_at(1, SEL_WE, 0, "rst_wait_e");
        exp_at(1, SEL_ST, 0, "rst_starve");
        exp_at(1, SEL_GE, 0, "rst_grant_err");
        drain();

        // Clean request: 2 sync + 4 debounce + 1 FSM edge
        do_reset();
        sn = 1'b1;
        exp_at(6, SEL_CN, 0, "clean_cn_early");
        exp_at(7, SEL_CN, 1, "clean_cn_rise");
        exp_at(7, SEL_WN, 0, "clean_wait_start");
        exp_at(7, SEL_CE, 0, "clean_ce_quiet");
        exp_at(10, SEL_WN, 3, "clean_wait_3");
        step(10);
        gn = 1'b1;
        exp_at(1, SEL_CN, 0, "clean_cn_drop");
        exp_at(1, SEL_WN, 0, "clean_wait_clear");
        step(1);
        gn = 1'b0;
        sn = 1'b0;
        exp_at(1, SEL_CN, 1, "clean_rerequest");
        drain();

        // Bounce rejection
        do_reset();
        for (int d = 1; d <= 32; d++) begin
            exp_at(d, SEL_CN, 0, "bounce_cn");
            if (d % 4 == 0) exp_at(d, SEL_WN, 0, "bounce_wait_n");
        end
        for (int i = 0; i < 10; i++) begin
            sn = (i % 2 == 0) ? 1'b1 : 1'b0;
            step(2);
        end
        sn = 1'b0;
        drain();

        // Held request after the car leaves
        do_reset();
        sn = 1'b1;
        exp_at(7, SEL_CN, 1, "held_cn_rise");
        exp_at(15, SEL_CN, 1, "held_cn_after_drop");
        exp_at(20, SEL_CN, 1, "held_cn_still");
        exp_at(20, SEL_WN, 13, "held_wait_13");
        step(10);
        sn = 1'b0;
        step(10);
        gn = 1'b1;
        exp_at(1, SEL_CN, 0, "held_cn_served");
        exp_at(1, SEL_WN, 0, "held_wait_clear");
        step(1);
        gn = 1'b0;
        exp_at(1, SEL_CN, 0, "held_idle_cn");
        exp_at(4, SEL_WN, 0, "held_idle_wait");
        exp_at(8, SEL_CN, 0, "held_idle_stays");
        drain();

        // Starvation and saturation, east first, north 3 cycles later
        do_reset();
        se = 1'b1;
        exp_at(7, SEL_CE, 1, "starve_ce_rise");
        exp_at(206, SEL_WE, 199, "starve_wait_e_199");
        exp_at(206, SEL_ST, 0, "starve_none_yet");
        exp_at(207, SEL_WE, 200, "starve_wait_e_200");
        exp_at(207, SEL_ST, 2, "starve_east_on");
        exp_at(209, SEL_WN, 199, "starve_wait_n_199");
        exp_at(209, SEL_ST, 2, "starve_east_only");
        exp_at(210, SEL_ST, 3, "starve_both");
        exp_at(261, SEL_WE, 254, "sat_wait_e_254");
        exp_at(262, SEL_WE, 255, "sat_wait_e_255");
        exp_at(265, SEL_WN, 255, "sat_wait_n_255");
        exp_at(270, SEL_WE, 255, "sat_wait_e_hold");
        exp_at(270, SEL_ST, 3, "sat_starve_hold");
        exp_at(280, SEL_WN, 255, "sat_wait_n_hold");
        step(3);
        sn = 1'b1;
        drain();

        // Double grant freezes counters and sets the sticky error
        do_reset();
        sn = 1'b1;
        exp_at(7, SEL_CN, 1, "err_cn_rise");
        exp_at(10, SEL_WN, 3, "err_wait_before");
        exp_at(10, SEL_GE, 0, "err_flag_clear");
        step(10);
        gn = 1'b1;
        ge = 1'b1;
        exp_at(1, SEL_GE, 1, "err_flag_set");
        exp_at(1, SEL_WN, 3, "err_wait_frozen");
        exp_at(1, SEL_CN, 1, "err_cn_frozen");
        exp_at(1, SEL_CE, 0, "err_ce_frozen");
        step(1);
        gn = 1'b0;
        ge = 1'b0;
        exp_at(1, SEL_WN, 4, "err_wait_resume");
        exp_at(9, SEL_GE, 1, "err_flag_sticky");
        exp_at(9, SEL_WN, 12, "err_wait_12");
        drain();

        // Asynchronous reset in PEND, checked between clock edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sn = 1'b0;
        #1;
        check("async_cn", int'(cn), 0);
        check("async_ce", int'(ce), 0);
        check("async_wait_n", int'(wait_n), 0);
        check("async_wait_e", int'(wait_e), 0);
        check("async_starve", int'(starve), 0);
        check("async_grant_err", int'(grant_err), 0);
        step(2);
        rst_n = 1'b1;
        step(4);
        sn = 1'b1;
        exp_at(6, SEL_CN, 0, "post_rst_cn_early");
        exp_at(7, SEL_CN, 1, "post_rst_cn_rise");
        exp_at(7, SEL_GE, 0, "post_rst_grant_err");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/car_request_conditioner.md
CAR_REQUEST_CONDITIONER -- requirements
Module: car_request_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable synchronized sensor cycles needed to change the filtered level (legal range 1..15).
REQ-002 Parameter WAIT_W, default 8: width of each wait counter.
REQ-003 Parameter STARVE_LIMIT, default 200: wait count at or above which the starve flag asserts (legal range 1..2^WAIT_W-1).
REQ-004 Clocking and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port sn, input, 1: raw north car sensor; asynchronous to clk; may bounce.
REQ-008 Port se, input, 1: raw east car sensor; asynchronous to clk; may bounce.
REQ-009 Port gn, input, 1: north grant fed back from the downstream arbiter.
REQ-010 Port ge, input, 1: east grant fed back from the downstream arbiter.
REQ-011 Port cn, output, 1: north request to the arbiter.
REQ-012 Port ce, output, 1: east request to the arbiter.
REQ-013 Port wait_n, output, WAIT_W: north pending-cycle count.
REQ-014 Port wait_e, output, WAIT_W: east pending-cycle count.
REQ-015 Port starve, output, 2: bit0 north and bit1 east; each bit indicates that direction's wait count is at or above STARVE_LIMIT.
REQ-016 Port grant_err, output, 1: sticky flag set when gn and ge are both high.

Function
REQ-017 Each sensor SHALL pass through a 2-flop synchronizer before any other logic.
REQ-018 Debounce: the filtered level SHALL take the synchronized value only after that value differs from the filtered level for DEB_CYCLES consecutive cycles; any mismatch-free cycle resets the stability count to 0.
REQ-019 Each direction SHALL run an independent FSM with states IDLE, PEND and SERVE; "filt" and "grant" below refer to that direction's own signals.
REQ-020 IDLE transitions: to SERVE if grant=1 and filt=1; else to PEND if filt=1; otherwise stay in IDLE.
REQ-021 PEND transitions: to SERVE if grant=1; otherwise stay in PEND, even if filt falls (a request once raised is held until served).
REQ-022 SERVE transitions: when grant=0, go to PEND if filt=1, otherwise to IDLE; while grant=1, stay in SERVE.
REQ-023 cn and ce SHALL be registered and equal to (state==PEND); the request drops in the cycle after grant is first sampled high.
REQ-024 Latency: a clean sensor rise SHALL produce a request exactly 2+DEB_CYCLES+1 clk edges later.
REQ-025 Wait counter: increments by 1 each cycle the FSM is in PEND; saturates at 2^WAIT_W-1 with no wrap; cleared to 0 on any transition out of PEND.
REQ-026 Each starve bit SHALL be a registered compare of its wait counter against STARVE_LIMIT.
REQ-027 If gn=1 and ge=1 in the same cycle: grant_err is set and stays set until reset; both FSMs and both wait counters hold their values for that cycle.
REQ-028 Both directions SHALL be handled fully concurrently; simultaneous events on north and east SHALL not interact, except as stated in REQ-027.

Reset
REQ-029 On rst_n=0, immediately and regardless of clk: synchronizers=0, filtered levels=0, stability counts=0, both FSMs=IDLE, cn=ce=0, wait_n=wait_e=0, starve=2'b00, grant_err=0.
REQ-030 Reset asserted mid-operation (including mid-debounce or in PEND) SHALL discard all state; after release the block SHALL behave as if from power-up.
REQ-031 Deassertion of rst_n SHALL be synchronized to clk inside the block.

Verification
REQ-032 Clean request with DEB_CYCLES=4: sn rises and is held, gn=0 -> cn=1 exactly 7 cycles later; assert gn for 1 cycle -> cn=0 on the next edge; wait_n returns to 0.
REQ-033 Bounce rejection: sn toggles every 2 cycles for 20 cycles, then stays 0 -> cn remains 0 throughout and the north FSM stays in IDLE.
REQ-034 Held request with no car: sn pulses high for 10 cycles, then drops, gn=0 -> cn stays 1; after gn pulses -> north FSM goes IDLE and cn=0.
REQ-035 Starvation and saturation with WAIT_W=8, STARVE_LIMIT=200, ce pending, ge=0 -> starve[1]=1 from wait_e=200 onward; wait_e holds at 255 and does not wrap.
REQ-036 Error and reset: drive gn=ge=1 for 1 cycle -> grant_err=1 and stays 1; assert rst_n=0 mid-PEND -> all outputs are 0 immediately, without a clk edge.
